// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter feeding the s2p stage.
// Takes one word per valid/ready handshake and streams it out one bit per clock on dext_o.
// An optional even-parity bit follows the data bits. en_o is high for exactly the frame.
// A fixed idle gap follows each frame before the next word is accepted.
module p2s_tx #(
  parameter int unsigned BIT       = 10,  // data word width, 2..32
  parameter int unsigned MSB_FIRST = 1,   // 1: din[BIT-1] first, 0: din[0] first
  parameter int unsigned PARITY    = 0,   // 1: append one even-parity bit
  parameter int unsigned GAP       = 2    // idle cycles after each frame, 0..255
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [BIT-1:0] din_i,
  input  logic           din_valid_i,
  output logic           din_ready_o,
  output logic           dext_o,
  output logic           en_o,
  output logic           tx_done_o
);

  localparam int unsigned     CntW    = (BIT > 1) ? $clog2(BIT) : 1;
  localparam logic [CntW-1:0] BitLast = CntW'(BIT - 1);
  localparam logic [7:0]      GapLast = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  typedef enum logic [1:0] {StIdle, StShift, StPar, StGap} state_e;

  state_e          state_q;
  logic [BIT-1:0]  sreg_q;
  logic [CntW-1:0] bit_cnt_q;
  logic [7:0]      gap_cnt_q;
  logic            par_q;
  logic            din_ready_q;
  logic            dext_q;
  logic            en_q;
  logic            tx_done_q;

  logic            first_bit;
  logic            next_bit;
  logic [BIT-1:0]  sreg_shift;
  logic            frame_last;

  // Bit ordering: which bit leads a frame, and how the shift register advances.
  always_comb begin
    if (MSB_FIRST != 0) begin
      first_bit  = din_i[BIT-1];
      next_bit   = sreg_q[BIT-2];
      sreg_shift = sreg_q << 1;
    end else begin
      first_bit  = din_i[0];
      next_bit   = sreg_q[1];
      sreg_shift = sreg_q >> 1;
    end
  end

  // The current cycle carries the final frame bit (data or parity).
  always_comb begin
    frame_last = 1'b0;
    if (state_q == StPar) begin
      frame_last = 1'b1;
    end else if (state_q == StShift && bit_cnt_q == BitLast && PARITY == 0) begin
      frame_last = 1'b1;
    end
  end

  // Frame FSM with all outputs registered; the leading bit is presented at the accept edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      sreg_q      <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      par_q       <= 1'b0;
      din_ready_q <= 1'b0;
      dext_q      <= 1'b0;
      en_q        <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      if (frame_last) begin
        en_q      <= 1'b0;
        dext_q    <= 1'b0;
        tx_done_q <= 1'b1;
        sreg_q    <= '0;
        bit_cnt_q <= '0;
        gap_cnt_q <= '0;
        if (GAP > 0) begin
          state_q <= StGap;
        end else begin
          state_q     <= StIdle;
          din_ready_q <= 1'b1;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            din_ready_q <= 1'b1;
            if (din_valid_i && din_ready_q) begin
              din_ready_q <= 1'b0;
              state_q     <= StShift;
              sreg_q      <= din_i;
              par_q       <= ^din_i;
              bit_cnt_q   <= '0;
              en_q        <= 1'b1;
              dext_q      <= first_bit;
            end
          end
          StShift: begin
            if (bit_cnt_q != BitLast) begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              sreg_q    <= sreg_shift;
              dext_q    <= next_bit;
            end else begin
              // Only reached with parity enabled; no-parity frames end via frame_last.
              state_q <= StPar;
              dext_q  <= par_q;
            end
          end
          StPar: begin
            state_q <= StIdle;
          end
          StGap: begin
            if (gap_cnt_q == GapLast) begin
              state_q     <= StIdle;
              din_ready_q <= 1'b1;
              gap_cnt_q   <= '0;
            end else begin
              gap_cnt_q <= gap_cnt_q + 8'd1;
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign din_ready_o = din_ready_q;
  assign dext_o      = dext_q;
  assign en_o        = en_q;
  assign tx_done_o   = tx_done_q;

endmodule
